// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
// Imported by the fetch unit, its skid buffer and the bus interface.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus.
// master = fetch side, slave = memory side.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} buffer holding a response
// that arrived while decode was stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_full,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_full;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_full  <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding
// imem fetch, stall hold and NOP bubble insertion.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] ResetPc  = 32'h0000_0000,
  parameter int          BitWidth = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [BitWidth-1:0] redirect_pc,
  fetch_unit_if.master        imem,
  output logic [BitWidth-1:0] instr,
  output logic [BitWidth-1:0] instr_pc,
  output logic                instr_valid
);

  fetch_state_t  r_state;
  fetch_state_t  w_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [31:0]   r_instr_pc;
  logic          r_instr_valid;
  logic          r_armed;

  logic          w_rsp;
  logic          w_accept;
  logic          w_deliver;
  logic          w_from_buf;
  logic          w_load;
  logic          w_clear;
  logic          w_buf_full;
  logic [31:0]   w_buf_instr;
  logic [31:0]   w_buf_pc;

  assign w_rsp    = imem.imem_rsp_valid;
  assign w_accept = imem.imem_req_valid
                  & imem.imem_req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= REQ;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      REQ: begin
        if (imem.imem_req_ready)
          w_next = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect_valid)
          w_next = w_rsp ? REQ : DROP;
        else if (w_rsp)
          w_next = stall ? HOLD : REQ;
      end
      HOLD: begin
        if (redirect_valid || !stall)
          w_next = REQ;
      end
      DROP: begin
        if (w_rsp) w_next = REQ;
      end
      default: w_next = REQ;
    endcase
  end

  always_comb begin
    imem.imem_req_valid = rst && (r_state == REQ);
    imem.imem_addr      = r_pc;
    w_deliver  = 1'b0;
    w_from_buf = 1'b0;
    w_load     = 1'b0;
    w_clear    = redirect_valid;
    if (!redirect_valid) begin
      unique case (r_state)
        WAIT: begin
          w_deliver = w_rsp && !stall;
          w_load    = w_rsp && stall;
        end
        HOLD: begin
          w_deliver  = w_buf_full && !stall;
          w_from_buf = 1'b1;
          w_clear    = !stall;
        end
        default: ;
      endcase
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_instr (imem.imem_rsp_data),
    .i_pc    (r_pc),
    .o_full  (w_buf_full),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= ResetPc;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      r_pc          <= redirect_pc & ~32'd3;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
    end else if (w_deliver) begin
      r_pc          <= r_pc + PC_STEP;
      r_instr       <= w_from_buf ? w_buf_instr
                                  : imem.imem_rsp_data;
      r_instr_pc    <= w_from_buf ? w_buf_pc : r_pc;
      r_instr_valid <= 1'b1;
    end else if (!stall) begin
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
    end
  end

  // Responses before the first post-reset request are pre-reset leftovers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_armed <= 1'b0;
    else if (w_accept) r_armed <= 1'b1;
  end

  a_rsp_protocol: assert property (
    @(posedge clk) disable iff (!rst || !r_armed)
    !(w_rsp && (r_state == REQ || r_state == HOLD))
  );

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Two instances: default reset PC and a wrapping reset PC.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;
  localparam logic [31:0] N = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        stall0, rdr0, stall1, rdr1;
  logic [31:0] rpc0, rpc1;
  logic [31:0] ins0, ipc0, ins1, ipc1;
  logic        iv0, iv1;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  always #5 clk = ~clk;

  fetch_unit u0 (
    .clk(clk), .rst(rst0), .stall(stall0),
    .redirect_valid(rdr0), .redirect_pc(rpc0),
    .imem(bus0), .instr(ins0), .instr_pc(ipc0),
    .instr_valid(iv0)
  );

  fetch_unit #(.ResetPc(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst1), .stall(stall1),
    .redirect_valid(rdr1), .redirect_pc(rpc1),
    .imem(bus1), .instr(ins1), .instr_pc(ipc1),
    .instr_valid(iv1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic out0(input string tag,
                      input logic [31:0] i,
                      input logic [31:0] p,
                      input logic v);
    chk({tag, ".instr"}, ins0, i);
    chk({tag, ".pc"}, ipc0, p);
    chk({tag, ".valid"}, {31'd0, iv0}, {31'd0, v});
  endtask

  task automatic req0(input string tag,
                      input logic v,
                      input logic [31:0] a);
    chk({tag, ".rv"}, {31'd0, bus0.imem_req_valid},
        {31'd0, v});
    if (v) chk({tag, ".addr"}, bus0.imem_addr, a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp0(input logic v, input logic [31:0] d);
    bus0.imem_rsp_valid = v;
    bus0.imem_rsp_data  = d;
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0;
    stall0 = 1'b0; rdr0 = 1'b0; rpc0 = '0;
    stall1 = 1'b0; rdr1 = 1'b0; rpc1 = '0;
    bus0.imem_req_ready = 1'b1;
    bus1.imem_req_ready = 1'b0;
    rsp0(1'b0, '0);
    bus1.imem_rsp_valid = 1'b0;
    bus1.imem_rsp_data  = '0;
    tick(); tick();
    out0("rst", N, 32'h0, 1'b0);
    req0("rst", 1'b0, 32'h0);

    rst0 = 1'b1; #1;
    req0("rel", 1'b1, 32'h0);
    tick();
    req0("w0", 1'b0, 32'h0);
    rsp0(1'b1, K);
    tick();
    out0("d0", K, 32'h0, 1'b1);
    req0("a4", 1'b1, 32'h4);
    rsp0(1'b0, '0);
    tick();
    out0("bub0", N, 32'h0, 1'b0);
    rsp0(1'b1, K ^ 32'h4);
    tick();
    out0("d4", K ^ 32'h4, 32'h4, 1'b1);
    req0("a8", 1'b1, 32'h8);
    rsp0(1'b0, '0);

    stall0 = 1'b1;
    tick();
    out0("st1", K ^ 32'h4, 32'h4, 1'b1);
    rsp0(1'b1, K ^ 32'h8);
    tick();
    out0("st2", K ^ 32'h4, 32'h4, 1'b1);
    req0("hold", 1'b0, 32'h0);
    rsp0(1'b0, '0);
    tick();
    out0("st3", K ^ 32'h4, 32'h4, 1'b1);
    req0("hold2", 1'b0, 32'h0);
    stall0 = 1'b0;
    tick();
    out0("d8", K ^ 32'h8, 32'h8, 1'b1);
    req0("aC", 1'b1, 32'hC);

    tick();
    out0("bubC", N, 32'h8, 1'b0);
    rdr0 = 1'b1; rpc0 = 32'h100;
    tick();
    out0("rdw", N, 32'h8, 1'b0);
    req0("drop", 1'b0, 32'h0);
    rdr0 = 1'b0;
    rsp0(1'b1, K ^ 32'hC);
    tick();
    out0("late", N, 32'h8, 1'b0);
    req0("a100", 1'b1, 32'h100);
    rsp0(1'b0, '0);
    tick();
    rsp0(1'b1, K ^ 32'h100);
    tick();
    out0("d100", K ^ 32'h100, 32'h100, 1'b1);
    req0("a104", 1'b1, 32'h104);
    rsp0(1'b0, '0);

    rdr0 = 1'b1; rpc0 = 32'h203; stall0 = 1'b1;
    tick();
    out0("rdr", N, 32'h100, 1'b0);
    req0("drop2", 1'b0, 32'h0);
    rdr0 = 1'b0; stall0 = 1'b0;
    rsp0(1'b1, K ^ 32'h104);
    tick();
    req0("a200", 1'b1, 32'h200);
    rsp0(1'b0, '0);
    tick();
    rsp0(1'b1, K ^ 32'h200);
    tick();
    out0("d200", K ^ 32'h200, 32'h200, 1'b1);
    rsp0(1'b0, '0);

    stall0 = 1'b1;
    tick();
    out0("pre", K ^ 32'h200, 32'h200, 1'b1);
    #2 rst0 = 1'b0;
    #1;
    out0("arst", N, 32'h0, 1'b0);
    req0("arst", 1'b0, 32'h0);
    stall0 = 1'b0;
    bus0.imem_req_ready = 1'b0;
    rsp0(1'b1, 32'hDEAD_BEEF);
    #1 rst0 = 1'b1;
    tick();
    out0("stray", N, 32'h0, 1'b0);
    req0("rs", 1'b1, 32'h0);
    rsp0(1'b0, '0);
    bus0.imem_req_ready = 1'b1;
    tick();
    rsp0(1'b1, K);
    tick();
    out0("dr0", K, 32'h0, 1'b1);
    rsp0(1'b0, '0);

    rst1 = 1'b1; bus1.imem_req_ready = 1'b1; #1;
    chk("w.a0", bus1.imem_addr, 32'hFFFF_FFF8);
    tick();
    bus1.imem_rsp_valid = 1'b1;
    bus1.imem_rsp_data  = 32'h1111_0000;
    tick();
    chk("w.pc0", ipc1, 32'hFFFF_FFF8);
    chk("w.a1", bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_rsp_valid = 1'b0;
    tick();
    bus1.imem_rsp_valid = 1'b1;
    tick();
    chk("w.pc1", ipc1, 32'hFFFF_FFFC);
    chk("w.a2", bus1.imem_addr, 32'h0);
    chk("w.rv", {31'd0, bus1.imem_req_valid}, 32'd1);
    bus1.imem_rsp_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
